receiver: RTL

UART receive path: 8N1 frames arriving on the serial line are turned into bytes, presented on a valid/ready handshake. It is the counterpart of the core's UART transmitter and shares its bit-timing parameter, so both ends of the link run at the same baud rate. Sits between the board RX pin and the core's input queue/loader.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync2.sv | 28 ++
 rtl/receiver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and
// bit-timing helpers derived from the half-bit period.
package uart_pkg;

  localparam int unsigned RX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  // Counter value at the middle of the start bit (counted from its falling edge).
  function automatic logic [31:0] half_bit_end(input int unsigned cphb);
    return 32'(cphb) - 32'd1;
  endfunction

  // Counter value one full bit period after the previous sample point.
  function automatic logic [31:0] full_bit_end(input int unsigned cphb);
    return (32'(cphb) << 1) - 32'd1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset
// to RST_VAL so an idle-high line does not look active out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // metastability filter chain
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/receiver.sv
// UART 8N1 receive path with valid/ready byte output, framing-error and
// overrun pulses. Optional build macro: RX_MAJORITY_VOTE_EN (2-of-3 sampling).
module receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       UART_RX,
  output logic [7:0] data_recv,
  output logic       valid_recv,
  input  logic       ready_recv,
  output logic       ferr,
  output logic       overrun
);

  localparam logic [2:0] LAST_IDX = 3'(RX_DATA_BITS - 1);

  logic        rx_s;
  logic        bit_s;
  rx_state_t   state_r;
  rx_state_t   state_nxt_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_nxt_s;
  logic [2:0]  idx_r;
  logic [7:0]  shreg_r;
  logic [7:0]  data_r;
  logic        valid_r;
  logic        ferr_r;
  logic        overrun_r;
  logic        half_hit_s;
  logic        full_hit_s;
  logic        shift_en_s;
  logic        deliver_s;
  logic        ferr_set_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (UART_RX),
    .q    (rx_s)
  );

`ifdef RX_MAJORITY_VOTE_EN
  // Decision lands one cycle late; the next bit counter starts at 1 to keep spacing.
  localparam logic [31:0] VOTE_OFS = 32'd1;
  logic [1:0] hist_r;

  // two previous synchronized samples for the 2-of-3 vote
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rx_s};
    end
  end

  assign bit_s = maj3(hist_r[1], hist_r[0], rx_s);
`else
  localparam logic [31:0] VOTE_OFS = 32'd0;
  assign bit_s = rx_s;
`endif

  localparam logic [31:0] HALF_DEC = half_bit_end(CLK_PER_HALF_BIT) + VOTE_OFS;
  localparam logic [31:0] FULL_DEC = full_bit_end(CLK_PER_HALF_BIT) + VOTE_OFS;

  assign half_hit_s = (cnt_r == HALF_DEC);
  assign full_hit_s = (cnt_r == FULL_DEC);

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!rx_s) state_nxt_s = S_START;
        else       state_nxt_s = S_IDLE;
      end
      S_START: begin
        if (half_hit_s) state_nxt_s = bit_s ? S_IDLE : S_DATA;
        else            state_nxt_s = S_START;
      end
      S_DATA: begin
        if (full_hit_s && (idx_r == LAST_IDX)) state_nxt_s = S_STOP;
        else                                   state_nxt_s = S_DATA;
      end
      S_STOP: begin
        if (full_hit_s) state_nxt_s = bit_s ? S_IDLE : S_BREAK;
        else            state_nxt_s = S_STOP;
      end
      S_BREAK: begin
        if (rx_s) state_nxt_s = S_IDLE;
        else      state_nxt_s = S_BREAK;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // per-state actions: counter reload, shift, delivery and error strobes
  always_comb begin
    cnt_nxt_s  = cnt_r + 32'd1;
    shift_en_s = 1'b0;
    deliver_s  = 1'b0;
    ferr_set_s = 1'b0;
    case (state_r)
      S_IDLE:  cnt_nxt_s = 32'd0;
      S_START: begin
        if (half_hit_s) cnt_nxt_s = bit_s ? 32'd0 : VOTE_OFS;
        else            cnt_nxt_s = cnt_r + 32'd1;
      end
      S_DATA: begin
        if (full_hit_s) begin
          shift_en_s = 1'b1;
          cnt_nxt_s  = VOTE_OFS;
        end else begin
          cnt_nxt_s  = cnt_r + 32'd1;
        end
      end
      S_STOP: begin
        if (full_hit_s) begin
          cnt_nxt_s  = 32'd0;
          deliver_s  = bit_s;
          ferr_set_s = ~bit_s;
        end else begin
          cnt_nxt_s  = cnt_r + 32'd1;
        end
      end
      S_BREAK: cnt_nxt_s = 32'd0;
      default: cnt_nxt_s = 32'd0;
    endcase
  end

  // datapath: bit counter, shift register and the output holding register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r     <= 32'd0;
      idx_r     <= 3'd0;
      shreg_r   <= 8'd0;
      data_r    <= 8'd0;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      ferr_r    <= ferr_set_s;
      overrun_r <= deliver_s && valid_r && !ready_recv;
      if (state_r == S_START) begin
        idx_r <= 3'd0;
      end else if (shift_en_s) begin
        idx_r <= idx_r + 3'd1;
      end
      if (shift_en_s) begin
        shreg_r <= {bit_s, shreg_r[7:1]};
      end
      // a consumer taking the old byte in the delivery cycle frees the slot
      if (deliver_s && (!valid_r || ready_recv)) begin
        data_r  <= shreg_r;
        valid_r <= 1'b1;
      end else if (valid_r && ready_recv) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data_recv  = data_r;
  assign valid_recv = valid_r;
  assign ferr       = ferr_r;
  assign overrun    = overrun_r;

endmodule
